reg_file_v3: RTL and testbench

REG_FILE_V3 -- requirements
Module: reg_file_v3

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file_rd_port.sv | 70 +++++++
 rtl/reg_file_v3.sv | 102 ++++++++++
 tb/tb_reg_file_v3.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and address-width helper for the reg_file_v3 register file.
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 10;

    // A one-register file would still need a one-bit address bus.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, optional write-first bypass, output register.
// Bypass is compiled in only when REG_FILE_V3_BYPASS_EN is defined.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = addr_w(DEFAULT_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
`ifdef REG_FILE_V3_BYPASS_EN
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
`endif
    output logic [WIDTH-1:0]       rd_data,
    output logic                   range_err
);

    logic             in_range_s;
    logic [WIDTH-1:0] reg_val_s;
    logic [WIDTH-1:0] next_data_s;
    logic [WIDTH-1:0] rd_data_r;

    // Address decode: pick the addressed register; out-of-range reads see zero.
    always_comb begin
        in_range_s = (32'(rd_addr) < 32'(DEPTH));
        range_err  = rd_en && !in_range_s;
        reg_val_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            reg_val_s = (32'(rd_addr) == 32'(i)) ? mem_flat[i*WIDTH +: WIDTH] : reg_val_s;
        end
    end

    // Next read value; a matching in-range write wins only when bypass is built in.
    always_comb begin
        next_data_s = '0;
        if (in_range_s) begin
`ifdef REG_FILE_V3_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr)) begin
                next_data_s = wr_data;
            end else begin
                next_data_s = reg_val_s;
            end
`else
            next_data_s = reg_val_s;
`endif
        end else begin
            next_data_s = '0;
        end
    end

    // Output register: loads only on an enabled read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= next_data_s;
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/reg_file_v3.sv
// Register file with one write port and two registered read ports (1-cycle latency).
// Define REG_FILE_V3_BYPASS_EN for write-first read-during-write; default is read-first.
module reg_file_v3
    import reg_file_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              addr_err
);

    logic [WIDTH-1:0]       mem_r [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat_s;
    logic                   wr_err_s;
    logic                   err_a_s;
    logic                   err_b_s;
    logic                   addr_err_r;

    // Write range check.
    always_comb begin
        wr_err_s = wr_en && (32'(wr_addr) >= 32'(DEPTH));
    end

    // Storage: the per-register compare makes out-of-range writes fall through untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && (32'(wr_addr) == 32'(i))) begin
                    mem_r[i] <= wr_data;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Flatten storage for the read ports.
    always_comb begin
        mem_flat_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_flat_s[i*WIDTH +: WIDTH] = mem_r[i];
        end
    end

    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) port_a (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en_a),
        .rd_addr   (rd_addr_a),
        .mem_flat  (mem_flat_s),
`ifdef REG_FILE_V3_BYPASS_EN
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`endif
        .rd_data   (rd_data_a),
        .range_err (err_a_s)
    );

    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) port_b (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en_b),
        .rd_addr   (rd_addr_b),
        .mem_flat  (mem_flat_s),
`ifdef REG_FILE_V3_BYPASS_EN
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`endif
        .rd_data   (rd_data_b),
        .range_err (err_b_s)
    );

    // Error pulse: set for the cycle following any out-of-range enabled access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err_r <= 1'b0;
        end else begin
            addr_err_r <= wr_err_s | err_a_s | err_b_s;
        end
    end

    assign addr_err = addr_err_r;

endmodule

// File: tb/tb_reg_file_v3.sv
// Self-checking bench for reg_file_v3: directed cases plus random traffic against a
// behavioural model, and a WIDTH=32/DEPTH=16 instance for the parameter sweep.
module tb_reg_file_v3;

    localparam int DEPTH = 10;
`ifdef REG_FILE_V3_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en_a, rd_en_b;
    logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wr_data, rd_data_a, rd_data_b;
    logic        addr_err;

    logic        s_wr_en, s_rd_en_a, s_rd_en_b;
    logic [3:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b;
    logic [31:0] s_wr_data, s_rd_data_a, s_rd_data_b;
    logic        s_addr_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [DEPTH];
    logic [15:0] exp_a, exp_b;
    logic        exp_err;

    always #5 clk = ~clk;

    reg_file_v3 dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .addr_err(addr_err)
    );

    reg_file_v3 #(.WIDTH(32), .DEPTH(16)) dut_wide (
        .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_en_a(s_rd_en_a), .rd_addr_a(s_rd_addr_a), .rd_en_b(s_rd_en_b), .rd_addr_b(s_rd_addr_b),
        .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b), .addr_err(s_addr_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
        exp_a   = 16'h0000;
        exp_b   = 16'h0000;
        exp_err = 1'b0;
    endtask

    // Drive one transaction from a negedge, let the clock edge happen, predict, check.
    task automatic cycle(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic rea, input logic [3:0] raa,
                         input logic reb, input logic [3:0] rab, input string tag);
        logic err;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_a = rea; rd_addr_a = raa; rd_en_b = reb; rd_addr_b = rab;
        @(posedge clk);
        err = 1'b0;
        if (rea) begin
            if (raa < DEPTH) exp_a = (BYPASS && we && wa == raa) ? wd : model_mem[raa];
            else begin exp_a = 16'h0000; err = 1'b1; end
        end
        if (reb) begin
            if (rab < DEPTH) exp_b = (BYPASS && we && wa == rab) ? wd : model_mem[rab];
            else begin exp_b = 16'h0000; err = 1'b1; end
        end
        if (we) begin
            if (wa < DEPTH) model_mem[wa] = wd;
            else err = 1'b1;
        end
        exp_err = err;
        #1;
        check_eq({tag, ".rd_a"}, 32'(rd_data_a), 32'(exp_a));
        check_eq({tag, ".rd_b"}, 32'(rd_data_b), 32'(exp_b));
        check_eq({tag, ".err"}, 32'(addr_err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        {wr_en, rd_en_a, rd_en_b} = 3'b000;
        {wr_addr, rd_addr_a, rd_addr_b} = 12'h000;
        wr_data = 16'h0000;
        {s_wr_en, s_rd_en_a, s_rd_en_b} = 3'b000;
        {s_wr_addr, s_rd_addr_a, s_rd_addr_b} = 12'h000;
        s_wr_data = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.rd_a", 32'(rd_data_a), 32'h0);
        check_eq("reset.rd_b", 32'(rd_data_b), 32'h0);
        check_eq("reset.err", 32'(addr_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Write then read reg 9, then hold with rd_en_a low.
        cycle(1'b1, 4'd9, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0, "wr9");
        cycle(1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 1'b0, 4'd0, "rd9");
        cycle(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, "hold9");
        check_eq("hold9.value", 32'(rd_data_a), 32'h1234);

        // Out-of-range read on B, then out-of-range write, then a clean cycle.
        cycle(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd12, "oor_rd");
        cycle(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, "oor_idle");
        cycle(1'b1, 4'd15, 16'hDEAD, 1'b0, 4'd0, 1'b0, 4'd0, "oor_wr");
        for (int i = 0; i < DEPTH; i += 2)
            cycle(1'b0, 4'd0, 16'h0000, 1'b1, 4'(i), 1'b1, 4'(i + 1), "scan");

        // Read-during-write on reg 5 from both ports.
        cycle(1'b1, 4'd5, 16'h00AA, 1'b0, 4'd0, 1'b0, 4'd0, "rdw_init");
        cycle(1'b1, 4'd5, 16'h5555, 1'b1, 4'd5, 1'b1, 4'd5, "rdw");
        check_eq("rdw.mode", 32'(rd_data_a), BYPASS ? 32'h5555 : 32'h00AA);
        cycle(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 4'd5, "rdw_after");

        // Randomized traffic.
        for (int n = 0; n < 400; n++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand");

        // Mid-run reset with non-zero outputs and a pending error pulse.
        cycle(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, "pre_rst_wr");
        cycle(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 4'd11, "pre_rst_rd");
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async.rd_a", 32'(rd_data_a), 32'h0);
        check_eq("rst_async.rd_b", 32'(rd_data_b), 32'h0);
        check_eq("rst_async.err", 32'(addr_err), 32'h0);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF;
        rd_en_a = 1'b1; rd_addr_a = 4'd3; rd_en_b = 1'b1; rd_addr_b = 4'd14;
        @(posedge clk);
        #1;
        check_eq("rst_hold.rd_a", 32'(rd_data_a), 32'h0);
        check_eq("rst_hold.err", 32'(addr_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 4'd3, "post_rst");

        // Wide instance: unique patterns on all 16 registers, no error ever.
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1'b1; s_wr_addr = 4'(i); s_wr_data = 32'hA5000000 ^ (32'(i) * 32'h01010101);
            @(posedge clk);
            #1;
            check_eq("wide.wr_err", 32'(s_addr_err), 32'h0);
            @(negedge clk);
        end
        s_wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_rd_en_a = 1'b1; s_rd_addr_a = 4'(i);
            s_rd_en_b = 1'b1; s_rd_addr_b = 4'(15 - i);
            @(posedge clk);
            #1;
            check_eq("wide.rd_a", s_rd_data_a, 32'hA5000000 ^ (32'(i) * 32'h01010101));
            check_eq("wide.rd_b", s_rd_data_b, 32'hA5000000 ^ (32'(15 - i) * 32'h01010101));
            check_eq("wide.rd_err", 32'(s_addr_err), 32'h0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
